rel_cmp_arbiter: RTL

//  Shares one relational comparator core among NUM_REQ requesters. Each request carries an operand pair (A,B).
//  A round-robin arbiter grants one request at a time and registers its operands. The comparator produces
//  eq/neq/gt/lt/gte/lte, which are returned tagged with the requester id over a valid/ready response channel.

---
 rtl/rel_cmp_pkg.sv | 36 +++
 rtl/rel_cmp_core.sv | 39 +++
 rtl/rel_cmp_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rel_cmp_pkg.sv
// Shared types, flag bit positions and the round-robin pick helper for rel_cmp_arbiter.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package rel_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int FLAG_EQ  = 5;
   localparam int FLAG_NEQ = 4;
   localparam int FLAG_GT  = 3;
   localparam int FLAG_LT  = 2;
   localparam int FLAG_GTE = 1;
   localparam int FLAG_LTE = 0;

   // First valid index scanning upward from ptr, wrapping mod n (n <= 16).
   // The scan runs from the farthest offset down to offset 0 so that the
   // nearest valid requester is the last one assigned and therefore wins.
   // With no valid bit set the result is ptr; callers gate on |valid.
   function automatic int rr_pick(input logic [15:0] valid, input int ptr, input int n);
      int result;
      int idx;
      result = ptr;
      for (int k = 15; k >= 0; k--) begin
         if (k < n) begin
            idx = (ptr + k) % n;
            if (valid[idx]) result = idx;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rel_cmp_core.sv
// Relational comparator: i_a, i_b -> o_flags {eq,neq,gt,lt,gte,lte}; purely combinational.
// Latency: 0 cycles.  Backpressure: none, no handshake.
// Ports: i_a, i_b [WIDTH-1:0] operands; o_flags [5:0] result. Macro REL_CMP_SIGNED_EN selects a signed compare.
module rel_cmp_core
   import rel_cmp_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [5:0]       o_flags
);

   logic w_eq;
   logic w_gt;
   logic w_lt;

   assign w_eq = (i_a == i_b);

`ifdef REL_CMP_SIGNED_EN
   // Operands are WIDTH-bit two's complement values.
   assign w_gt = ($signed(i_a) > $signed(i_b));
   assign w_lt = ($signed(i_a) < $signed(i_b));
`else
   assign w_gt = (i_a > i_b);
   assign w_lt = (i_a < i_b);
`endif

   always_comb begin
      o_flags           = '0;
      o_flags[FLAG_EQ]  = w_eq;
      o_flags[FLAG_NEQ] = ~w_eq;
      o_flags[FLAG_GT]  = w_gt;
      o_flags[FLAG_LT]  = w_lt;
      o_flags[FLAG_GTE] = w_gt | w_eq;
      o_flags[FLAG_LTE] = w_lt | w_eq;
   end

endmodule

// File: rtl/rel_cmp_arbiter.sv
// Round-robin shares one rel_cmp_core among NUM_REQ requesters and returns id-tagged compare flags.
// Latency: handshake in cycle N -> rsp_valid in cycle N+2; at most one compare in flight (1 per 3 cycles best case).
// Backpressure: response held stable while rsp_valid & !rsp_ready; req_ready stays 0 whenever busy.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_a/req_b per requester; rsp_valid/rsp_ready/rsp_id/rsp_flags.
// Macro REL_CMP_SIGNED_EN (in rel_cmp_core) switches to a signed compare.
module rel_cmp_arbiter
   import rel_cmp_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [5:0]               rsp_flags
);

   state_t           r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [IDW-1:0]   r_op_id;
   logic             r_rsp_valid;
   logic [IDW-1:0]   r_rsp_id;
   logic [5:0]       r_rsp_flags;

   logic [IDW-1:0]     w_g;
   logic [NUM_REQ-1:0] w_onehot;
   logic               w_hs;
   logic [5:0]         w_flags;
   logic [IDW-1:0]     w_ptr_nxt;

   assign w_g      = IDW'(rr_pick(16'(req_valid), int'(r_rr_ptr), NUM_REQ));
   assign w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_g;

   // Grant only while idle and out of reset; one-hot by construction.
   assign req_ready = (rst_n && (r_state == IDLE) && (|req_valid)) ? w_onehot : '0;
   assign w_hs      = |(req_valid & req_ready);

   // Pointer moves just past the requester being served.
   assign w_ptr_nxt = (r_op_id == IDW'(NUM_REQ - 1)) ? '0 : r_op_id + IDW'(1);

   rel_cmp_core #(.WIDTH(WIDTH)) u_core (
      .i_a     (r_op_a),
      .i_b     (r_op_b),
      .o_flags (w_flags)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_id     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_flags <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_op_a  <= req_a[w_g*WIDTH +: WIDTH];
                  r_op_b  <= req_b[w_g*WIDTH +: WIDTH];
                  r_op_id <= w_g;
                  r_state <= CMP;
               end
            end
            CMP: begin
               r_rsp_flags <= w_flags;
               r_rsp_id    <= r_op_id;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rr_ptr    <= w_ptr_nxt;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_flags = r_rsp_flags;

endmodule
